lane_game_ctrl: RTL and testbench

Game-logic stage directly upstream of the VGA renderer and the LED/seven-segment status logic. Owns the player lane position, six horizontally moving obstacle blocks, collision/goal detection, two-player turn alternation and scoring. Produces the registered positions the renderer draws each frame, plus the state and score values the LED and SSD logic display.

---
 rtl/lane_game_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lane_game_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_game_ctrl.sv
// Lane-crossing game logic: player lane, six wrapping obstacle blocks, hit/goal detection, turns and scores.
// Build option LANE_SPEED_VAR_EN: block k advances k pixels per tick instead of 1.
module lane_game_ctrl #(
    parameter int unsigned PLAYER_X   = 320,
    parameter int unsigned LANE_PITCH = 60,
    parameter int unsigned HIT_HALF   = 30,
    parameter int unsigned WIN_SCORE  = 10,
    parameter int unsigned SCREEN_W   = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        move_tick,
    input  logic        btnU,
    input  logic        btnD,
    output logic [9:0]  Yposition_player,
    output logic [59:0] block_x,
    output logic [1:0]  state,
    output logic [3:0]  p1_score,
    output logic [3:0]  p2_score,
    output logic        hit,
    output logic        goal
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGame1 = 2'b01,
        StGame2 = 2'b10,
        StDone  = 2'b11
    } state_e;

    localparam logic [10:0] WinLo    = 11'(PLAYER_X - HIT_HALF);
    localparam logic [10:0] WinHi    = 11'(PLAYER_X + HIT_HALF);
    localparam logic [10:0] ScreenW  = 11'(SCREEN_W);
    localparam logic [3:0]  WinScore = 4'(WIN_SCORE);
    localparam logic [9:0]  Pitch    = 10'(LANE_PITCH);

    state_e            state_q, state_d;
    logic [2:0]        lane_q, lane_d;
    logic [9:0]        y_q, y_d;
    logic [5:0][9:0]   bx_q, bx_d;
    logic [3:0]        p1_q, p1_d, p2_q, p2_d;
    logic              hit_q, hit_d, goal_q, goal_d;
    logic              check_q, check_d;

    logic [9:0]        cur_x;
    logic              lane_blk, collide, at_goal;
    logic [3:0]        score_inc;

    function automatic logic [9:0] advance(input logic [9:0] x, input logic [10:0] step);
        logic [10:0] sum;
        sum = {1'b0, x} + step;
        return (sum >= ScreenW) ? 10'(sum - ScreenW) : sum[9:0];
    endfunction

    // Block under the player (only lanes 1..6 carry a block).
    always_comb begin
        cur_x    = '0;
        lane_blk = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (lane_q == 3'(k)) begin
                cur_x    = bx_q[k-1];
                lane_blk = 1'b1;
            end
        end
    end

    assign collide   = lane_blk && ({1'b0, cur_x} > WinLo) && ({1'b0, cur_x} < WinHi);
    assign at_goal   = (lane_q == 3'd7);
    assign score_inc = ((state_q == StGame2) ? p2_q : p1_q) + 4'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StGame1;
            end
            StGame1, StGame2: begin
                if (check_q) begin
                    if (collide) begin
                        state_d = (state_q == StGame1) ? StGame2 : StGame1;
                    end else if (at_goal && (score_inc == WinScore)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Datapath and pulse next values
    always_comb begin
        lane_d  = lane_q;
        bx_d    = bx_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        hit_d   = 1'b0;
        goal_d  = 1'b0;
        check_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    p1_d   = '0;
                    p2_d   = '0;
                    lane_d = '0;
                end
            end
            StGame1, StGame2: begin
                if (check_q) begin
                    // Ticks during the check cycle are dropped.
                    if (collide) begin
                        hit_d  = 1'b1;
                        lane_d = '0;
                    end else if (at_goal) begin
                        goal_d = 1'b1;
                        lane_d = '0;
                        if (state_q == StGame2) p2_d = score_inc;
                        else                    p1_d = score_inc;
                    end
                end else if (move_tick) begin
                    check_d = 1'b1;
                    for (int k = 0; k < 6; k++) begin
`ifdef LANE_SPEED_VAR_EN
                        bx_d[k] = advance(bx_q[k], 11'(k + 1));
`else
                        bx_d[k] = advance(bx_q[k], 11'd1);
`endif
                    end
                    if (btnD && !btnU) begin
                        lane_d = (lane_q == 3'd7) ? 3'd7 : lane_q + 3'd1;
                    end else if (btnU && !btnD) begin
                        lane_d = (lane_q == 3'd0) ? 3'd0 : lane_q - 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign y_d = Pitch * {7'd0, lane_d};

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q  <= '0;
            y_q     <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            hit_q   <= 1'b0;
            goal_q  <= 1'b0;
            check_q <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                bx_q[k] <= 10'(100 * k);
            end
        end else begin
            lane_q  <= lane_d;
            y_q     <= y_d;
            bx_q    <= bx_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            hit_q   <= hit_d;
            goal_q  <= goal_d;
            check_q <= check_d;
        end
    end

    assign Yposition_player = y_q;
    assign block_x          = bx_q;
    assign state            = state_q;
    assign p1_score         = p1_q;
    assign p2_score         = p2_q;
    assign hit              = hit_q;
    assign goal             = goal_q;

endmodule

// File: tb/tb_lane_game_ctrl.sv
// Bench for lane_game_ctrl: directed scenario then random play, checked against a behavioural game model.
module tb_lane_game_ctrl;

    localparam int PX    = 320;
    localparam int PITCH = 60;
    localparam int HH    = 30;
    localparam int WIN   = 10;
    localparam int W     = 640;

    logic        clk = 1'b0;
    logic        reset, start, move_tick, btnU, btnD;
    logic [9:0]  Yposition_player;
    logic [59:0] block_x;
    logic [1:0]  state;
    logic [3:0]  p1_score, p2_score;
    logic        hit, goal;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the game
    int m_state, m_lane, m_p1, m_p2, m_hit, m_goal;
    bit m_pend;
    int m_bx[6];
    int t;  // accepted ticks since the last reset

    always #5 clk = ~clk;

    lane_game_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .move_tick        (move_tick),
        .btnU             (btnU),
        .btnD             (btnD),
        .Yposition_player (Yposition_player),
        .block_x          (block_x),
        .state            (state),
        .p1_score         (p1_score),
        .p2_score         (p2_score),
        .hit              (hit),
        .goal             (goal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int speed(input int k);
`ifdef LANE_SPEED_VAR_EN
        return k + 1;
`else
        return 1;
`endif
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit mt, input bit up,
                              input bit dn);
        int d;
        m_hit  = 0;
        m_goal = 0;
        if (rst) begin
            m_state = 0; m_lane = 0; m_p1 = 0; m_p2 = 0; m_pend = 0; t = 0;
            for (int k = 0; k < 6; k++) m_bx[k] = 100 * k;
        end else if (m_state == 0) begin
            if (st) begin
                m_state = 1; m_p1 = 0; m_p2 = 0; m_lane = 0;
            end
        end else if (m_state == 3) begin
            m_hit = 0;
        end else if (m_pend) begin
            m_pend = 0;
            d = (m_lane >= 1 && m_lane <= 6) ? m_bx[m_lane-1] - PX : HH;
            if (d < 0) d = -d;
            if (d < HH) begin
                m_hit = 1; m_lane = 0; m_state = 3 - m_state;
            end else if (m_lane == 7) begin
                m_goal = 1; m_lane = 0;
                if (m_state == 1) begin
                    m_p1++;
                    if (m_p1 == WIN) m_state = 3;
                end else begin
                    m_p2++;
                    if (m_p2 == WIN) m_state = 3;
                end
            end
        end else if (mt) begin
            m_pend = 1;
            t++;
            for (int k = 0; k < 6; k++) m_bx[k] = (m_bx[k] + speed(k)) % W;
            if (dn && !up)      m_lane = (m_lane < 7) ? m_lane + 1 : 7;
            else if (up && !dn) m_lane = (m_lane > 0) ? m_lane - 1 : 0;
        end
    endtask

    task automatic cycle(input bit rst, input bit st, input bit mt, input bit up, input bit dn);
        reset = rst; start = st; move_tick = mt; btnU = up; btnD = dn;
        model_step(rst, st, mt, up, dn);
        @(posedge clk);
        #1;
        chk("y", 32'(Yposition_player), PITCH * m_lane);
        for (int k = 0; k < 6; k++) chk($sformatf("bx%0d", k + 1), 32'(block_x[k*10 +: 10]), m_bx[k]);
        chk("state", 32'(state), m_state);
        chk("p1", 32'(p1_score), m_p1);
        chk("p2", 32'(p2_score), m_p2);
        chk("hit", 32'(hit), m_hit);
        chk("goal", 32'(goal), m_goal);
    endtask

    // One accepted tick followed by its check cycle.
    task automatic tick_pair(input bit up, input bit dn);
        cycle(1'b0, 1'b0, 1'b1, up, dn);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        bit mt, up, dn;
        reset = 1'b1; start = 1'b0; move_tick = 1'b0; btnU = 1'b0; btnD = 1'b0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_bx6", 32'(block_x[59:50]), 500);

        cycle(0, 0, 1, 0, 1);                 // tick in idle ignored
        cycle(0, 1, 1, 0, 1);                 // tick alongside start dropped
        chk("start_state", 32'(state), 1);
        chk("start_y", 32'(Yposition_player), 0);
        chk("start_bx4", 32'(block_x[39:30]), 300);

        repeat (60) tick_pair(0, 0);
        for (int j = 1; j <= 7; j++) begin
            cycle(0, 0, 1, 0, 1);
            chk("walk_y", 32'(Yposition_player), PITCH * j);
            cycle(0, 0, 0, 0, 0);
        end
        chk("goal_pulse", 32'(goal), 1);
        chk("goal_p1", 32'(p1_score), 1);
        chk("goal_y", 32'(Yposition_player), 0);
        chk("goal_state", 32'(state), 1);
        cycle(0, 0, 0, 0, 0);
        chk("goal_once", 32'(goal), 0);

        // Block 3 at X=300 when the player lands in lane 3
        repeat (30) tick_pair(0, 0);
        repeat (3) tick_pair(0, 1);
        chk("hit300", 32'(hit), 1);
        chk("hit300_y", 32'(Yposition_player), 0);
        chk("hit300_state", 32'(state), 2);

        // Block 3 at X=350: outside the window
        repeat (47) tick_pair(0, 0);
        repeat (3) tick_pair(0, 1);
        chk("edge350", 32'(hit), 0);
        chk("edge350_y", 32'(Yposition_player), 180);
        repeat (3) tick_pair(1, 0);

        // Block 3 at X=290, crossing the block-1 wrap from 639 to 0 on the way
        repeat (574) begin
            tick_pair(0, 0);
            if (t % W == 0) chk("wrap_bx1", 32'(block_x[9:0]), 0);
        end
        repeat (3) tick_pair(0, 1);
        chk("edge290", 32'(hit), 0);
        chk("edge290_y", 32'(Yposition_player), 180);

        // Back-to-back ticks: the second one lands in the check cycle
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        chk("adj_y", 32'(Yposition_player), 240);
        cycle(0, 0, 0, 0, 0);

        // Reset during a check cycle
        cycle(0, 0, 1, 0, 1);
        cycle(1, 0, 0, 0, 0);
        chk("rstchk_hit", 32'(hit), 0);
        chk("rstchk_goal", 32'(goal), 0);
        chk("rstchk_state", 32'(state), 0);
        chk("rstchk_y", 32'(Yposition_player), 0);

        // Random play until someone wins
        cycle(0, 1, 0, 0, 0);
        n = 0;
        while (m_state != 3 && n < 30000) begin
            mt = 1'($urandom_range(0, 1));
            dn = ($urandom_range(0, 9) < 8);
            up = ($urandom_range(0, 9) < 1);
            cycle(0, 0, mt, up, dn);
            n++;
        end
        chk("reach_done", 32'(state), 3);
        chk("win_score", 32'((m_p1 == WIN) ? p1_score : p2_score), WIN);

        repeat (20) begin
            cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("done_hold", 32'(state), 3);

        cycle(1, 0, 0, 0, 0);
        chk("final_rst", 32'(state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
